// File: rtl/hamm_inj_pkg.sv
// Shared types and helpers for the Hamming(16,11) channel-noise injector.
// Optional log feature: define HAMM_INJ_LOG_EN.
package hamm_inj_pkg;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Taps x^16+x^14+x^13+x^11+1 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

`ifdef HAMM_INJ_LOG_EN
  localparam int unsigned CYC_PER_WORD = 6;
`else
  localparam int unsigned CYC_PER_WORD = 4;
`endif

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
`ifdef HAMM_INJ_LOG_EN
    LOG_A,
    LOG_B,
`endif
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RAND   = 2'd0,
    NONE   = 2'd1,
    SINGLE = 2'd2,
    DOUBLE = 2'd3
  } inj_mode_t;

  // Second flip position; a zero offset is bumped to 1 so pos2 never equals pos1
  function automatic logic [3:0] flip_pos2(logic [7:0] s_lo);
    logic [3:0] off;
    off = (s_lo[7:4] == 4'd0) ? 4'd1 : s_lo[7:4];
    return 4'(s_lo[3:0] + off);
  endfunction

  // Number of flips for this word; forced modes override only the count
  function automatic logic [1:0] flip_count(logic [1:0] s_top, inj_mode_t mode);
    logic [1:0] cnt;
    case (mode)
      NONE:    cnt = 2'd0;
      SINGLE:  cnt = 2'd1;
      DOUBLE:  cnt = 2'd2;
      default: cnt = (s_top == 2'b00) ? 2'd0 : ((s_top == 2'b11) ? 2'd2 : 2'd1);
    endcase
    return cnt;
  endfunction

  // XOR mask built from the selected positions and count
  function automatic logic [15:0] flip_mask(logic [3:0] pos1, logic [3:0] pos2, logic [1:0] cnt);
    logic [15:0] m1;
    logic [15:0] m2;
    m1 = 16'(1) << pos1;
    m2 = 16'(1) << pos2;
    case (cnt)
      2'd0:    return 16'h0000;
      2'd1:    return m1;
      default: return m1 | m2;
    endcase
  endfunction

endpackage

// File: rtl/hamm_chan_inject_lfsr16.sv
// 16-bit Fibonacci LFSR with zero-seed substitution.
module lfsr16
  import hamm_inj_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed_in,
  output logic [15:0] state
);

  // Load has priority; a zero seed would lock the LFSR, so substitute the default
  always_ff @(posedge clk) begin
    if (load) begin
      state <= (seed_in == 16'h0000) ? LFSR_DEFAULT_SEED : seed_in;
    end else if (step) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/hamm_chan_inject.sv
// Channel-noise stage: copies encoded words SRC->DST, XORing 0/1/2 bit flips.
// Optional per-word injection log: define HAMM_INJ_LOG_EN.
module hamm_chan_inject
  import hamm_inj_pkg::*;
#(
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 64,
  parameter int unsigned NWORDS   = 15,
  parameter int unsigned LOG_BASE = 224
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] seed,
  input  logic [1:0]  inj_mode,
  output logic        ack,
  output logic [7:0]  MemAdr,
  output logic [7:0]  DatIn,
  input  logic [7:0]  DatOut,
  output logic        ReadEn,
  output logic        WriteEn,
  output logic [5:0]  flips_total
);

  localparam int unsigned IDX_W = 8;

  // Bases are byte addresses on an 8-bit bus; the index must not overflow IDX_W
  if (SRC_BASE > 255 || DST_BASE > 255 || LOG_BASE > 255 || NWORDS == 0 || NWORDS > 127) begin : g_bad_param
    $error("hamm_chan_inject: bad address or word-count parameter");
  end

  state_t           state;
  inj_mode_t        mode_q;
  logic [IDX_W-1:0] idx;
  logic [7:0]       lo;
  logic [7:0]       hi;
  logic [15:0]      lfsr_state;

  logic             lfsr_load_c;
  logic             lfsr_step_c;
  logic [15:0]      lfsr_seed_c;
  logic             lfsr_unused_c;
  logic [3:0]       pos1_c;
  logic [3:0]       pos2_c;
  logic [1:0]       cnt_c;
  logic [15:0]      mask_c;
  logic [IDX_W-1:0] idx_inc_c;
  logic [7:0]       src_adr_c;
  logic [7:0]       dst_adr_c;

  // Reset and arm both (re)load the LFSR; it advances once per finished word
  assign lfsr_load_c = reset | req;
  assign lfsr_seed_c = reset ? 16'h0000 : seed;
  assign lfsr_step_c = !reset && !req && (state == WR_HI);

  lfsr16 u_lfsr (
    .clk     (clk),
    .load    (lfsr_load_c),
    .step    (lfsr_step_c),
    .seed_in (lfsr_seed_c),
    .state   (lfsr_state)
  );

  // Flip selection from the current LFSR state
  assign lfsr_unused_c = ^lfsr_state[13:8];
  assign pos1_c = lfsr_state[3:0];
  assign pos2_c = flip_pos2(lfsr_state[7:0]);
  assign cnt_c  = flip_count(lfsr_state[15:14], mode_q);
  assign mask_c = flip_mask(pos1_c, pos2_c, cnt_c);

  // Word addresses wrap mod 256
  assign idx_inc_c = idx + IDX_W'(1);
  assign src_adr_c = 8'(SRC_BASE + 2 * 32'(idx));
  assign dst_adr_c = 8'(DST_BASE + 2 * 32'(idx));

`ifdef HAMM_INJ_LOG_EN
  logic [7:0] log_adr_c;
  logic [1:0] log_cnt;
  assign log_adr_c = 8'(LOG_BASE + 2 * 32'(idx));
`else
  logic [7:0] src_nxt_adr_c;
  assign src_nxt_adr_c = 8'(SRC_BASE + 2 * 32'(idx_inc_c));
`endif

  // Control FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= RAND;
      idx         <= '0;
      lo          <= '0;
      hi          <= '0;
      ack         <= 1'b0;
      MemAdr      <= '0;
      DatIn       <= '0;
      ReadEn      <= 1'b0;
      WriteEn     <= 1'b0;
      flips_total <= '0;
`ifdef HAMM_INJ_LOG_EN
      log_cnt     <= '0;
`endif
    end else if (req) begin
      state       <= ARM;
      mode_q      <= inj_mode_t'(inj_mode);
      idx         <= '0;
      ack         <= 1'b0;
      ReadEn      <= 1'b0;
      WriteEn     <= 1'b0;
      flips_total <= '0;
    end else begin
      ReadEn  <= 1'b0;
      WriteEn <= 1'b0;
      case (state)
        ARM: begin
          state  <= RD_LO;
          MemAdr <= src_adr_c;
          ReadEn <= 1'b1;
        end
        RD_LO: begin
          lo     <= DatOut;
          state  <= RD_HI;
          MemAdr <= 8'(MemAdr + 8'd1);
          ReadEn <= 1'b1;
        end
        RD_HI: begin
          hi      <= DatOut;
          state   <= WR_LO;
          MemAdr  <= dst_adr_c;
          DatIn   <= lo ^ mask_c[7:0];
          WriteEn <= 1'b1;
        end
        WR_LO: begin
          state   <= WR_HI;
          MemAdr  <= 8'(MemAdr + 8'd1);
          DatIn   <= hi ^ mask_c[15:8];
          WriteEn <= 1'b1;
        end
        WR_HI: begin
          flips_total <= 6'(flips_total + 6'(cnt_c));
          idx         <= idx_inc_c;
`ifdef HAMM_INJ_LOG_EN
          state   <= LOG_A;
          MemAdr  <= log_adr_c;
          DatIn   <= {pos2_c, pos1_c};
          WriteEn <= 1'b1;
          log_cnt <= cnt_c;
`else
          if (idx_inc_c == IDX_W'(NWORDS)) begin
            state <= DONE;
            ack   <= 1'b1;
          end else begin
            state  <= RD_LO;
            MemAdr <= src_nxt_adr_c;
            ReadEn <= 1'b1;
          end
`endif
        end
`ifdef HAMM_INJ_LOG_EN
        LOG_A: begin
          state   <= LOG_B;
          MemAdr  <= 8'(MemAdr + 8'd1);
          DatIn   <= {6'b0, log_cnt};
          WriteEn <= 1'b1;
        end
        LOG_B: begin
          if (idx == IDX_W'(NWORDS)) begin
            state <= DONE;
            ack   <= 1'b1;
          end else begin
            state  <= RD_LO;
            MemAdr <= src_adr_c;
            ReadEn <= 1'b1;
          end
        end
`endif
        DONE: begin
          ack <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamm_chan_inject.sv
// Directed self-checking bench for hamm_chan_inject with a byte-wide data memory.
// Honours HAMM_INJ_LOG_EN for the log checks and run length.
module tb_hamm_chan_inject;
  import hamm_inj_pkg::CYC_PER_WORD;

  localparam int NW = 15;
`ifdef HAMM_INJ_LOG_EN
  localparam int   ACK_EDGE = 91;
  localparam logic EXP_WE19 = 1'b0;
`else
  localparam int   ACK_EDGE = 61;
  localparam logic EXP_WE19 = 1'b1;
`endif
  localparam int BUDGET = int'(CYC_PER_WORD) * NW * 2 + 20;

  logic        clk;
  logic        reset;
  logic        req;
  logic [15:0] seed;
  logic [1:0]  inj_mode;
  logic        ack;
  logic [7:0]  MemAdr;
  logic [7:0]  DatIn;
  logic [7:0]  DatOut;
  logic        ReadEn;
  logic        WriteEn;
  logic [5:0]  flips_total;

  logic [7:0]  mem [256];
  logic        tb_we;
  logic [7:0]  tb_adr;
  logic [7:0]  tb_dat;
  int          stray_wr = 0;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  exp_dst [30];
  int          exp_flips;
  int          n_edges;

  hamm_chan_inject dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .seed        (seed),
    .inj_mode    (inj_mode),
    .ack         (ack),
    .MemAdr      (MemAdr),
    .DatIn       (DatIn),
    .DatOut      (DatOut),
    .ReadEn      (ReadEn),
    .WriteEn     (WriteEn),
    .flips_total (flips_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign DatOut = mem[MemAdr];

  // Data memory: bench preload port has priority over the DUT write port
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_adr] <= tb_dat;
    end else if (WriteEn) begin
      mem[MemAdr] <= DatIn;
`ifdef HAMM_INJ_LOG_EN
      if (!((MemAdr >= 8'd64 && MemAdr < 8'd94) || (MemAdr >= 8'd224 && MemAdr < 8'd254)))
        stray_wr <= stray_wr + 1;
`else
      if (!(MemAdr >= 8'd64 && MemAdr < 8'd94))
        stray_wr <= stray_wr + 1;
`endif
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input int k);
    if (k == 0) return 8'h5A;
    if (k == 1) return 8'hC3;
    return 8'(k * 29 + 7);
  endfunction

  task automatic poke(input logic [7:0] adr, input logic [7:0] dat);
    @(negedge clk);
    tb_we  = 1'b1;
    tb_adr = adr;
    tb_dat = dat;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic clear_dst();
    for (int k = 0; k < 2 * NW; k++) poke(8'(64 + k), 8'h00);
  endtask

  // Reference: per-word LFSR walk and flip selection
  task automatic model_run(input logic [1:0] mode, input logic [15:0] sd);
    logic [15:0] s;
    logic [15:0] m;
    logic [15:0] w;
    int p1, p2, off, cnt;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    exp_flips = 0;
    for (int k = 0; k < NW; k++) begin
      p1  = int'(s[3:0]);
      off = int'(s[7:4]);
      if (off == 0) off = 1;
      p2  = (p1 + off) % 16;
      case (mode)
        2'd0:    cnt = (s[15:14] == 2'b00) ? 0 : ((s[15:14] == 2'b11) ? 2 : 1);
        2'd1:    cnt = 0;
        2'd2:    cnt = 1;
        default: cnt = 2;
      endcase
      m = 16'h0000;
      if (cnt >= 1) m[p1] = 1'b1;
      if (cnt == 2) m[p2] = 1'b1;
      w = {src_byte(2 * k + 1), src_byte(2 * k)} ^ m;
      exp_dst[2 * k]     = w[7:0];
      exp_dst[2 * k + 1] = w[15:8];
      exp_flips += cnt;
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
  endtask

  // Arm for one clock, then release; mode/seed are scrambled after release
  task automatic start_run(input logic [1:0] mode, input logic [15:0] sd);
    @(negedge clk);
    req      = 1'b1;
    inj_mode = mode;
    seed     = sd;
    @(negedge clk);
    req      = 1'b0;
    inj_mode = ~mode;
    seed     = ~sd;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk);
      #1 n++;
      if (ack) break;
    end
    if (!ack) n = BUDGET + 1;
  endtask

  task automatic check_dst(input string tag);
    for (int k = 0; k < 2 * NW; k++)
      check_val($sformatf("%s_dst%0d", tag, k), 32'(mem[64 + k]), 32'(exp_dst[k]));
  endtask

  task automatic run_case(input string tag, input logic [1:0] mode, input logic [15:0] sd);
    clear_dst();
    model_run(mode, sd);
    start_run(mode, sd);
    wait_ack(n_edges);
    check_val($sformatf("%s_ack_edge", tag), 32'(n_edges), 32'(ACK_EDGE));
    check_val($sformatf("%s_flips", tag), 32'(flips_total), 32'(exp_flips));
    check_dst(tag);
  endtask

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    seed     = 16'h0000;
    inj_mode = 2'd0;
    tb_we    = 1'b0;
    tb_adr   = 8'h00;
    tb_dat   = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack",    32'(ack),         32'(0));
    check_val("rst_we",     32'(WriteEn),     32'(0));
    check_val("rst_re",     32'(ReadEn),      32'(0));
    check_val("rst_adr",    32'(MemAdr),      32'(0));
    check_val("rst_datin",  32'(DatIn),       32'(0));
    check_val("rst_flips",  32'(flips_total), 32'(0));

    for (int k = 0; k < 2 * NW; k++) poke(8'(30 + k), src_byte(k));
    for (int k = 0; k < 2 * NW; k++) poke(8'(224 + k), 8'hEE);
    @(negedge clk) reset = 1'b0;

    // Forced none: exact copy
    run_case("none", 2'd1, 16'h1234);
    check_val("none_lo0", 32'(mem[64]), 32'h5A);
    check_val("none_hi0", 32'(mem[65]), 32'hC3);
    check_val("none_flips0", 32'(flips_total), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check_val("done_ack_hold", 32'(ack),     32'(1));
    check_val("done_we",       32'(WriteEn), 32'(0));
    check_val("done_re",       32'(ReadEn),  32'(0));

    // Forced single, seed 3: pos1=3
    run_case("single", 2'd2, 16'h0003);
    check_val("single_lo0", 32'(mem[64]), 32'h52);
    check_val("single_hi0", 32'(mem[65]), 32'hC3);
    check_val("single_flips15", 32'(flips_total), 32'(15));

    // Forced double, seed 5: pos1=5, pos2=6
    run_case("double", 2'd3, 16'h0005);
    check_val("double_lo0", 32'(mem[64]), 32'h3A);
    check_val("double_hi0", 32'(mem[65]), 32'hC3);
    check_val("double_flips30", 32'(flips_total), 32'(30));
`ifdef HAMM_INJ_LOG_EN
    check_val("log_pos0", 32'(mem[224]), 32'h65);
    check_val("log_cnt0", 32'(mem[225]), 32'h02);
`else
    check_val("log_untouched0", 32'(mem[224]), 32'hEE);
    check_val("log_untouched1", 32'(mem[225]), 32'hEE);
`endif

    // Random mode, zero seed -> 16'hACE1: single flip at bit 1
    run_case("rand", 2'd0, 16'h0000);
    check_val("rand_lo0", 32'(mem[64]), 32'h58);

    // Abort at edge 20, then rerun from the arm state
    clear_dst();
    model_run(2'd2, 16'h0003);
    start_run(2'd2, 16'h0003);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    check_val("abort_we19", 32'(WriteEn), 32'(EXP_WE19));
    @(negedge clk);
    req      = 1'b1;
    inj_mode = 2'd2;
    seed     = 16'h0003;
    @(posedge clk);
    #1;
    check_val("abort_ack",   32'(ack),         32'(0));
    check_val("abort_we",    32'(WriteEn),     32'(0));
    check_val("abort_flips", 32'(flips_total), 32'(0));
    clear_dst();
    @(negedge clk) req = 1'b0;
    wait_ack(n_edges);
    check_val("rerun_ack_edge", 32'(n_edges), 32'(ACK_EDGE));
    check_val("rerun_flips", 32'(flips_total), 32'(exp_flips));
    check_dst("rerun");

    // Reset mid-run
    start_run(2'd1, 16'h0000);
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_ack",   32'(ack),         32'(0));
    check_val("midrst_we",    32'(WriteEn),     32'(0));
    check_val("midrst_re",    32'(ReadEn),      32'(0));
    check_val("midrst_adr",   32'(MemAdr),      32'(0));
    check_val("midrst_datin", 32'(DatIn),       32'(0));
    check_val("midrst_flips", 32'(flips_total), 32'(0));
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("idle_ack", 32'(ack),    32'(0));
    check_val("idle_re",  32'(ReadEn), 32'(0));

    check_val("stray_writes", 32'(stray_wr), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hamm_chan_inject.md
Name: hamm_chan_inject

Overview:
- Channel-noise stage between the Hamming(16,11) SECDED encoder and decoder programs.
- Walks NWORDS encoded 16-bit words in data memory (SRC_BASE..), XORs 0, 1 or 2 bit flips into each word, and writes the results to the decoder's input region (DST_BASE..).
- Uses the same req/ack handshake as the processor under test and acts as bus master on the dm port.
- Flip selection comes from an LFSR or a forced mode.

Parameters:
- SRC_BASE, 30, byte address of word 0 low byte in the encoded region; the high byte is at +1.
- DST_BASE, 64, byte address of word 0 low byte in the decoder input region.
- NWORDS, 15, number of 16-bit words processed per run.
- LOG_BASE, 224, first byte of the injection log; used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  high = arm and hold; the run starts on the first clock with req low.
- seed  in  16  LFSR seed, sampled every clock while req is high.
- inj_mode  in  2  0=LFSR-random, 1=force none, 2=force single, 3=force double; sampled while req is high.
- ack  out  1  run complete; held until next req.
- MemAdr  out  8  dm address.
- DatIn  out  8  dm write data.
- DatOut  in  8  dm read data; combinational read of MemAdr.
- ReadEn  out  1  dm read enable.
- WriteEn  out  1  dm write enable; write at rising edge.
- flips_total  out  6  total bits flipped this run (0..30).

Behaviour:
- Reset: ack=0, WriteEn=0, ReadEn=0, MemAdr=0, DatIn=0, flips_total=0, word index=0, LFSR=16'hACE1, state IDLE.
- States: IDLE, ARM, RD_LO, RD_HI, WR_LO, WR_HI, [LOG_A, LOG_B], DONE.
- req high in any state -> ARM next clock:
  - ack=0, index=0, flips_total=0.
  - Load LFSR with seed; a seed of 0 loads 16'hACE1.
  - Latch inj_mode.
  - A run in progress is abandoned; memory bytes already written stay written.
- ARM with req low -> RD_LO.
- RD_LO: MemAdr=SRC_BASE+2i, ReadEn=1; capture DatOut into lo.
- RD_HI: MemAdr=SRC_BASE+2i+1; capture hi.
- WR_LO: MemAdr=DST_BASE+2i, DatIn=(word^mask)[7:0], WriteEn=1.
- WR_HI: MemAdr=DST_BASE+2i+1, DatIn=(word^mask)[15:8], WriteEn=1.
  - At the end of WR_HI: LFSR steps once; flips_total += flip count; i++.
  - If i==NWORDS, go to DONE; else go to RD_LO (or to LOG_A when the log is enabled).
- Mask is computed from current LFSR state s:
  - pos1=s[3:0]; off=s[7:4]; pos2=(pos1+(off==0?1:off)) mod 16, so pos2 is never equal to pos1.
  - Random mode count: s[15:14]=00 -> 0 flips; 01 or 10 -> 1 flip; 11 -> 2 flips.
  - Forced modes override the count only; positions still come from s.
  - mask = count==0: 0; count==1: 1<<pos1; count==2: (1<<pos1)|(1<<pos2).
- LFSR: Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback = s[15]^s[13]^s[12]^s[10] into bit 0.
- Address arithmetic is 8-bit and wraps mod 256.
- Timing: 4 clocks per word (6 with the log enabled).
  - ack rises at the clock edge NWORDS*4+1 edges after the first edge with req low; 61 with defaults.
  - In DONE: ack=1, ReadEn=0, WriteEn=0. Stays until req or reset.
- Outside the read and write states: WriteEn=0. MemAdr and DatIn hold their last value.
- Reset takes priority over req.

Optional Feature:
- Macro HAMM_INJ_LOG_EN.
- When defined: after WR_HI, two extra states run:
  - LOG_A writes {pos2,pos1} to LOG_BASE+2i.
  - LOG_B writes {6'b0,count} to LOG_BASE+2i+1.
  - Run length becomes NWORDS*6+1 clocks.
- When undefined: LOG states are absent, and LOG_BASE is never addressed or written.

Decomposition:
- Package hamm_inj_pkg:
  - state_t enum;
  - inj_mode_t enum (RAND, NONE, SINGLE, DOUBLE);
  - LFSR_DEFAULT_SEED=16'hACE1;
  - LFSR tap mask;
  - CYC_PER_WORD constant (4 or 6 under the macro).
- Sub-module lfsr16: ports clk, load, step, seed_in, state. The zero-seed substitution lives inside it.
- The FSM, mask generation and bus driving stay in the top module.

Test Plan:
- inj_mode=1, mem[30]=8'h5A, mem[31]=8'hC3 -> mem[64]=8'h5A, mem[65]=8'hC3; all 30 bytes copied exactly; flips_total=0; ack at edge 61.
- inj_mode=2, seed=16'h0003 -> word 0 gets pos1=3, so mem[64]=8'h52, mem[65]=8'hC3; flips_total=15 at ack.
- inj_mode=3, seed=16'h0005 -> word 0 gets pos1=5, off=0, pos2=6, mask 16'h0060, so mem[64]=8'h3A; flips_total=30.
- inj_mode=0, seed=16'h0000 -> LFSR loads 16'hACE1 (s[15:14]=10 gives single flip, pos1=1), so mem[64]=8'h58; bench model of LFSR matches all 15 words.
- Abort and recover:
  - Raise req at edge 20 of a run -> ack stays 0; WriteEn drops the next clock.
  - Rerun with req low -> completes in 61 edges from index 0.
  - Asserting reset mid-run instead gives all outputs at reset values the next edge.
- With HAMM_INJ_LOG_EN defined, inj_mode=3, seed=16'h0005 -> mem[224]=8'h65, mem[225]=8'h02; ack at edge 91.
